// File: rtl/param_datapath_pkg.sv
// Shared types for the parametrised two-stage datapath.
// Holds the ALU opcodes, the clear/run states and the command control fields.
package param_datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_NOT   = 3'd5,
    ALU_PASSA = 3'd6,
    ALU_INC   = 3'd7
  } alu_op_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dp_state_e;

  // Width-independent part of a command. Addresses stay as separate
  // vectors because their widths follow the module parameters.
  typedef struct packed {
    logic    d_wr;
    logic    rf_s;
    logic    w_en;
    alu_op_e alu_sel;
  } dp_cmd_t;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// No reset; the datapath clears it through the write port after reset.
module dp_regfile #(
  parameter  int DATA_W   = 16,
  parameter  int RF_DEPTH = 16,
  localparam int RW       = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [RW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [RW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [RF_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/param_datapath.sv
// Two-stage (execute / writeback) datapath with RF clear after reset and W->E forwarding.
// Define PARAM_DATAPATH_FLAGS_EN to add the registered zero/negative/carry flag outputs.
//
//   state | meaning
//   INIT  | clearing rf[cnt] each edge, cmd_ready low
//   RUN   | accepting one command per cycle
module param_datapath
  import param_datapath_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int RF_DEPTH   = 16,
  parameter  int DMEM_DEPTH = 256,
  localparam int RW         = $clog2(RF_DEPTH),
  localparam int AW         = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AW-1:0]     cmd_d_addr,
  input  logic              cmd_d_wr,
  input  logic              cmd_rf_s,
  input  logic [RW-1:0]     cmd_w_addr,
  input  logic              cmd_w_en,
  input  logic [RW-1:0]     cmd_ra,
  input  logic [RW-1:0]     cmd_rb,
  input  logic [2:0]        cmd_alu_sel,
  output logic              wb_valid,
  output logic [RW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data
`ifdef PARAM_DATAPATH_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
`endif
);

  dp_state_e         state_q, state_d;
  logic [RW-1:0]     clr_cnt_q, clr_cnt_d;
  dp_cmd_t           cmd;
  logic              accept;

  logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b, alu_res;
  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q;

  logic              w_valid_q, w_en_q, w_rf_s_q;
  logic [RW-1:0]     w_addr_q;
  logic [DATA_W-1:0] w_alu_q;
  logic [DATA_W-1:0] w_data;

  assign cmd = '{d_wr: cmd_d_wr, rf_s: cmd_rf_s, w_en: cmd_w_en,
                 alu_sel: alu_op_e'(cmd_alu_sel)};

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == RW'(RF_DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign cmd_ready = (state_q == RUN);
  assign accept    = cmd_valid & cmd_ready & ~reset;

  // A W op caught by reset is dropped: neither reported nor written.
  assign w_data   = w_rf_s_q ? dmem_q : w_alu_q;
  assign wb_valid = w_valid_q & w_en_q & ~reset;
  assign wb_addr  = wb_valid ? w_addr_q : '0;
  assign wb_data  = wb_valid ? w_data : '0;

  assign rf_we    = (state_q == INIT) | wb_valid;
  assign rf_waddr = (state_q == INIT) ? clr_cnt_q : w_addr_q;
  assign rf_wdata = (state_q == INIT) ? '0 : w_data;

  dp_regfile #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH)
  ) u_regfile (
    .clk       (clk),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (cmd_ra),
    .rdata_a_o (rf_a),
    .raddr_b_i (cmd_rb),
    .rdata_b_o (rf_b)
  );

  assign op_a = (wb_valid && (w_addr_q == cmd_ra)) ? w_data : rf_a;
  assign op_b = (wb_valid && (w_addr_q == cmd_rb)) ? w_data : rf_b;

  always_comb begin
    alu_res = '0;
    case (cmd.alu_sel)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_NOT:   alu_res = ~op_a;
      ALU_PASSA: alu_res = op_a;
      ALU_INC:   alu_res = op_a + 1'b1;
      default:   alu_res = '0;
    endcase
  end

  // Non-blocking read and write on the same edge: a store+load command reads the old word.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (cmd.d_wr) begin
        dmem[cmd_d_addr] <= op_a;
      end
      dmem_q <= dmem[cmd_d_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q <= 1'b0;
      w_en_q    <= 1'b0;
      w_rf_s_q  <= 1'b0;
      w_addr_q  <= '0;
      w_alu_q   <= '0;
    end else begin
      w_valid_q <= accept;
      if (accept) begin
        w_en_q   <= cmd.w_en;
        w_rf_s_q <= cmd.rf_s;
        w_addr_q <= cmd_w_addr;
        w_alu_q  <= alu_res;
      end
    end
  end

`ifdef PARAM_DATAPATH_FLAGS_EN
  logic carry;
  logic flag_z_q, flag_n_q, flag_c_q;

  // Unsigned carry/borrow recovered from the wrapped result.
  always_comb begin
    carry = 1'b0;
    case (cmd.alu_sel)
      ALU_ADD: carry = (alu_res < op_a);
      ALU_SUB: carry = (op_a < op_b);
      ALU_INC: carry = &op_a;
      default: carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (accept) begin
      flag_z_q <= (alu_res == '0);
      flag_n_q <= alu_res[DATA_W-1];
      flag_c_q <= carry;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_c = flag_c_q;
`endif

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: vector table with a writeback scoreboard,
// hand-written reset/clear sequences, and a small-parameter instance for wrap checks.
module tb_param_datapath;

  typedef struct {
    bit          valid;
    logic [2:0]  op;
    logic [3:0]  ra, rb, wa;
    bit          we, dwr, rfs;
    logic [7:0]  da;
    bit          ewb;
    logic [15:0] edata;
    bit          cf;
    logic [2:0]  fl;   // {z, n, c}
    string       name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst = 1'b1;
  logic        c_valid = 1'b0, c_dwr = 1'b0, c_rfs = 1'b0, c_we = 1'b0;
  logic [7:0]  c_daddr = '0;
  logic [3:0]  c_waddr = '0, c_ra = '0, c_rb = '0;
  logic [2:0]  c_alu = '0;
  logic        cmd_ready, wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  // Small instance: DATA_W=8, RF_DEPTH=4, DMEM_DEPTH=16
  logic        rst2 = 1'b1;
  logic        c2_valid = 1'b0, c2_we = 1'b0;
  logic [3:0]  c2_daddr = '0;
  logic [1:0]  c2_waddr = '0, c2_ra = '0, c2_rb = '0;
  logic [2:0]  c2_alu = '0;
  logic        rdy2, wbv2;
  logic [1:0]  wba2;
  logic [7:0]  wbd2;

`ifdef PARAM_DATAPATH_FLAGS_EN
  logic fz, fn, fc, fz2, fn2, fc2;
`endif

  param_datapath dut (
    .clk(clk), .reset(rst), .cmd_valid(c_valid), .cmd_ready(cmd_ready),
    .cmd_d_addr(c_daddr), .cmd_d_wr(c_dwr), .cmd_rf_s(c_rfs),
    .cmd_w_addr(c_waddr), .cmd_w_en(c_we), .cmd_ra(c_ra), .cmd_rb(c_rb),
    .cmd_alu_sel(c_alu), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef PARAM_DATAPATH_FLAGS_EN
    , .flag_z(fz), .flag_n(fn), .flag_c(fc)
`endif
  );

  param_datapath #(.DATA_W(8), .RF_DEPTH(4), .DMEM_DEPTH(16)) dut2 (
    .clk(clk), .reset(rst2), .cmd_valid(c2_valid), .cmd_ready(rdy2),
    .cmd_d_addr(c2_daddr), .cmd_d_wr(1'b0), .cmd_rf_s(1'b0),
    .cmd_w_addr(c2_waddr), .cmd_w_en(c2_we), .cmd_ra(c2_ra), .cmd_rb(c2_rb),
    .cmd_alu_sel(c2_alu), .wb_valid(wbv2), .wb_addr(wba2), .wb_data(wbd2)
`ifdef PARAM_DATAPATH_FLAGS_EN
    , .flag_z(fz2), .flag_n(fn2), .flag_c(fc2)
`endif
  );

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vt[$];
  vec_t sb[$];

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t cv(string nm, int op, int ra, int rb, int wa, bit we,
                              bit dwr, bit rfs, int da, bit ewb, int edata,
                              bit cf, logic [2:0] fl);
    vec_t v;
    v.valid = 1'b1; v.op = 3'(op); v.ra = 4'(ra); v.rb = 4'(rb); v.wa = 4'(wa);
    v.we = we; v.dwr = dwr; v.rfs = rfs; v.da = 8'(da);
    v.ewb = ewb; v.edata = 16'(edata); v.cf = cf; v.fl = fl; v.name = nm;
    return v;
  endfunction

  function automatic vec_t bub(string nm, logic [2:0] fl);
    vec_t v;
    v = cv(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, fl);
    v.valid = 1'b0;
    return v;
  endfunction

  function automatic void check_pending();
    vec_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    cmp({e.name, "_wb_valid"}, 32'(wb_valid), 32'(e.ewb));
    if (e.ewb) begin
      cmp({e.name, "_wb_addr"}, 32'(wb_addr), 32'(e.wa));
      cmp({e.name, "_wb_data"}, 32'(wb_data), 32'(e.edata));
    end
`ifdef PARAM_DATAPATH_FLAGS_EN
    if (e.cf) cmp({e.name, "_flags"}, 32'({fz, fn, fc}), 32'(e.fl));
`endif
  endfunction

  task automatic apply(vec_t v);
    @(negedge clk);
    check_pending();
    c_valid = v.valid; c_alu = v.op; c_ra = v.ra; c_rb = v.rb; c_waddr = v.wa;
    c_we = v.we; c_dwr = v.dwr; c_rfs = v.rfs; c_daddr = v.da;
    if (v.valid) cmp({v.name, "_ready"}, 32'(cmd_ready), 32'd1);
    sb.push_back(v);
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
    c_valid = 1'b0;
  endtask

  task automatic wait_init(string nm, bit second, int exp_edges);
    int edges = 0;
    bit rdy = 1'b0;
    while (!rdy && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      rdy = second ? rdy2 : cmd_ready;
      if (!rdy) begin
        cmp({nm, "_wb_idle"}, 32'(second ? wbv2 : wb_valid), 32'd0);
        if (!second) cmp({nm, "_wb_data_idle"}, 32'(wb_data), 32'd0);
      end
    end
    cmp({nm, "_init_edges"}, 32'(edges), 32'(exp_edges));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x;
    logic [15:0] pattern;

    // Table: RF clear check, build 0x1234 in r1 through forwarded ops, then the load/store chain.
    for (int i = 0; i < 16; i++)
      vt.push_back(cv($sformatf("rf0_r%0d", i), 6, i, i, i, 1, 0, 0, 0, 1, 0, 1, 3'b100));
    x = 16'd1;
    vt.push_back(cv("build_inc", 7, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 3'b000));
    pattern = 16'h1234;
    for (int b = 11; b >= 0; b--) begin
      x = x + x;
      vt.push_back(cv($sformatf("build_dbl%0d", b), 0, 1, 1, 1, 1, 0, 0, 0, 1, int'(x), 1, 3'b000));
      if (pattern[b]) begin
        x = x + 16'd1;
        vt.push_back(cv($sformatf("build_inc%0d", b), 7, 1, 0, 1, 1, 0, 0, 0, 1, int'(x), 1, 3'b000));
      end
    end
    vt.push_back(cv("st_05",        6, 1, 0, 0, 0, 1, 0, 'h05, 0, 0,       1, 3'b000));
    vt.push_back(bub("idle0", 3'b000));
    vt.push_back(cv("ld_05",        6, 0, 0, 2, 1, 0, 1, 'h05, 1, 'h1234,  1, 3'b100));
    vt.push_back(cv("fwd_ld_add",   0, 2, 2, 3, 1, 0, 0, 0,    1, 'h2468,  1, 3'b000));
    vt.push_back(cv("st_10",        6, 3, 0, 0, 0, 1, 0, 'h10, 0, 0,       1, 3'b000));
    vt.push_back(cv("ld_10",        6, 0, 0, 4, 1, 0, 1, 'h10, 1, 'h2468,  1, 3'b100));
    vt.push_back(cv("rdw_old",      6, 4, 0, 5, 1, 1, 1, 'h05, 1, 'h1234,  1, 3'b000));
    vt.push_back(cv("ld_05_new",    6, 0, 0, 6, 1, 0, 1, 'h05, 1, 'h2468,  1, 3'b100));
    vt.push_back(cv("inc_r1",       7, 0, 0, 1, 1, 0, 0, 0,    1, 'h0001,  1, 3'b000));
    vt.push_back(cv("sub_neg",      1, 0, 1, 1, 1, 0, 0, 0,    1, 'hFFFF,  1, 3'b011));
    vt.push_back(cv("inc_wrap",     7, 1, 0, 1, 1, 0, 0, 0,    1, 'h0000,  1, 3'b101));
    vt.push_back(cv("and",          2, 2, 3, 8, 1, 0, 0, 0,    1, 'h0020,  1, 3'b000));
    vt.push_back(cv("or",           3, 2, 3, 8, 1, 0, 0, 0,    1, 'h367C,  1, 3'b000));
    vt.push_back(cv("xor",          4, 2, 3, 8, 1, 0, 0, 0,    1, 'h365C,  1, 3'b000));
    vt.push_back(cv("not",          5, 2, 0, 9, 1, 0, 0, 0,    1, 'hEDCB,  1, 3'b010));
    vt.push_back(cv("sub_borrow",   1, 2, 3, 10, 1, 0, 0, 0,   1, 'hEDCC,  1, 3'b011));
    vt.push_back(cv("add_carry",    0, 9, 3, 11, 1, 0, 0, 0,   1, 'h1233,  1, 3'b001));
    vt.push_back(cv("sub_nowe",     1, 2, 3, 8, 0, 0, 0, 0,    0, 0,       1, 3'b011));
    vt.push_back(bub("idle_hold", 3'b011));
    vt.push_back(cv("nowe_keeps_r8", 6, 8, 0, 13, 1, 0, 0, 0,  1, 'h365C,  1, 3'b000));

    // Reset and clear sequence
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_ready", 32'(cmd_ready), 32'd0);
    cmp("rst_wb_valid", 32'(wb_valid), 32'd0);
    cmp("rst_wb_addr", 32'(wb_addr), 32'd0);
    cmp("rst_wb_data", 32'(wb_data), 32'd0);
`ifdef PARAM_DATAPATH_FLAGS_EN
    cmp("rst_flags", 32'({fz, fn, fc}), 32'd0);
`endif
    rst = 1'b0;
    wait_init("init", 1'b0, 16);

    foreach (vt[i]) apply(vt[i]);
    flush();

    // Reset arrives the cycle after ADD r7 is accepted: the write must vanish.
    c_valid = 1'b1; c_alu = 3'd0; c_ra = 4'd3; c_rb = 4'd3; c_waddr = 4'd7;
    c_we = 1'b1; c_dwr = 1'b0; c_rfs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    c_valid = 1'b0;
    #1;
    cmp("midrst_no_wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    cmp("midrst_ready_drop", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    wait_init("reinit", 1'b0, 16);
    apply(cv("r7_cleared", 6, 7, 0, 7, 1, 0, 0, 0, 1, 0, 1, 3'b100));
    apply(cv("r3_cleared", 0, 3, 3, 3, 1, 0, 0, 0, 1, 0, 1, 3'b100));
    flush();

    // Narrow instance: 4-edge clear and 8-bit wrap
    @(negedge clk);
    rst2 = 1'b0;
    wait_init("init2", 1'b1, 4);
    c2_valid = 1'b1; c2_we = 1'b1; c2_alu = 3'd7; c2_ra = 2'd0; c2_rb = 2'd0; c2_waddr = 2'd1;
    @(negedge clk);
    cmp("n_inc_valid", 32'(wbv2), 32'd1);
    cmp("n_inc_data", 32'(wbd2), 32'h01);
    c2_alu = 3'd1; c2_ra = 2'd0; c2_rb = 2'd1;
    @(negedge clk);
    cmp("n_sub_data", 32'(wbd2), 32'hFF);
`ifdef PARAM_DATAPATH_FLAGS_EN
    cmp("n_sub_flags", 32'({fz2, fn2, fc2}), 32'b011);
`endif
    c2_alu = 3'd7; c2_ra = 2'd1;
    @(negedge clk);
    cmp("n_wrap_valid", 32'(wbv2), 32'd1);
    cmp("n_wrap_addr", 32'(wba2), 32'd1);
    cmp("n_wrap_data", 32'(wbd2), 32'h00);
`ifdef PARAM_DATAPATH_FLAGS_EN
    cmp("n_wrap_flags", 32'({fz2, fn2, fc2}), 32'b101);
`endif
    c2_valid = 1'b0;
    @(negedge clk);
    cmp("n_idle", 32'(wbv2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
